inst_fifo: RTL and testbench
============================

INST_FIFO -- requirements
Module: inst_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, giving the queue capacity in entries; it SHALL be a power of two and at least 4.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port flush, input, 1 bit: discard all queued entries (branch mispredict or exception).
REQ-005 The module SHALL have ports in_valid1 and in_valid2, inputs, 1 bit each: fetch slot 1 and slot 2 data are valid.
REQ-006 The module SHALL have ports in_pc1, in_inst1, in_pc2 and in_inst2, inputs, 32 bits each: fetched PC and instruction for each slot.
REQ-007 The module SHALL have port full, output, 1 bit: fewer than 2 free entries; upstream holds fetch.
REQ-008 The module SHALL have ports out_valid1 and out_valid2, outputs, 1 bit each: issue slot 1 and slot 2 hold valid entries.
REQ-009 The module SHALL have ports out_pc1, out_inst1, out_pc2 and out_inst2, outputs, 32 bits each: the oldest and second-oldest queued entries.
REQ-010 The module SHALL have ports issue1 and issue2, inputs, 1 bit each: decode consumes slot 1, and slot 2 in addition.
REQ-011 The module SHALL have port count, output, log2(DEPTH)+1 bits: the current number of occupied entries.

Function
REQ-012 The module SHALL store entries in a circular buffer of DEPTH x 64 bits (pc, inst), with read pointer, write pointer and count; both pointers SHALL wrap modulo DEPTH.
REQ-013 The number of entries pushed SHALL be in_valid1 + in_valid2; when both are valid, slot 1 SHALL be written before slot 2; in_valid2 alone SHALL write one entry taken from slot 2.
REQ-014 Pushes SHALL be accepted only when full=0; pushes presented while full=1 SHALL be dropped with no state change.
REQ-015 full SHALL be 1 exactly when count > DEPTH-2.
REQ-016 out_valid1 SHALL be (count>=1) and out_valid2 SHALL be (count>=2); out_* data SHALL be driven combinationally from mem[rd_ptr] and mem[(rd_ptr+1) mod DEPTH].
REQ-017 The number of entries popped SHALL be 1 for issue1&~issue2 and 2 for issue1&issue2; issue2 without issue1 SHALL be ignored; a pop of an entry whose out_valid is 0 SHALL be ignored.
REQ-018 When push and pop occur in the same cycle, count SHALL update by +pushes-pops in that cycle, and neither operation SHALL block the other.
REQ-019 A pushed entry SHALL first appear on the out_* ports in the cycle after the push (1-cycle latency), except as provided by REQ-025.
REQ-020 flush SHALL take priority over everything else: on the next edge, count, rd_ptr and wr_ptr SHALL be 0, and any push or pop in the flush cycle SHALL be discarded.
REQ-021 out_* data SHALL be don't-care when the matching out_valid is 0.

Reset
REQ-022 While resetn=0, rd_ptr, wr_ptr and count SHALL be 0, giving full=0, out_valid1=0 and out_valid2=0 immediately and asynchronously.
REQ-023 Buffer contents SHALL NOT require reset.
REQ-024 Reset asserted mid-operation SHALL discard all entries; the first push accepted after deassertion SHALL be the first entry issued.

Configuration
REQ-025 With macro INST_FIFO_BYPASS_EN defined: when count=0 and flush=0, the out_* ports SHALL reflect the in_* ports in the same cycle, out_valid1/out_valid2 SHALL follow the in_valid inputs with slot-1-first packing, and issued bypass entries SHALL NOT be written while unissued ones SHALL be queued.
REQ-026 Without INST_FIFO_BYPASS_EN: no combinational path from the in_* ports to the out_* ports SHALL exist, and REQ-019 latency SHALL always apply.

Verification
REQ-027 Reset with DEPTH=16, then push pairs (pc 0xBFC00000/04, inst 0x11111111/0x22222222) without issue for 7 cycles -> count=14, full=0; on the 8th pair -> count=16, full=1; a 9th pair is dropped and count stays 16.
REQ-028 From count=16, issue1&issue2 for 8 cycles -> pcs appear in order 0xBFC00000, +4, ... with wrap across the index 15->0 boundary; count reaches 0 and out_valid1=0.
REQ-029 count=3, simultaneous push of 2 and issue of 2 -> next cycle count=3 and out_pc1 equals the previous 3rd-oldest entry.
REQ-030 count=5, flush with in_valid1=in_valid2=1 and issue1=1 -> next cycle count=0, out_valid1=0, full=0.
REQ-031 count=0, push single pc 0xBFC00010 with issue1=1 -> without BYPASS_EN, out_valid1=0 that cycle and pc 0xBFC00010 issues the next cycle; with BYPASS_EN, out_pc1=0xBFC00010 that cycle and count stays 0.
REQ-032 Assert resetn=0 mid-burst at count=9 -> count=0 and out_valid1=0 before the next clock edge.

Source files
------------

// File: rtl/inst_fifo_if.sv
// Fetch-to-decode instruction queue bus: two push slots from fetch and two issue slots to decode.
// Handshake: the fetch side presents in_valid* only while full=0; any offer made with full=1 is dropped.
// The decode side sees out_valid* and pulses issue1 (optionally with issue2) to consume in order.
interface inst_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid1;
  logic          in_valid2;
  logic [31:0]   in_pc1;
  logic [31:0]   in_inst1;
  logic [31:0]   in_pc2;
  logic [31:0]   in_inst2;
  logic          full;
  logic          out_valid1;
  logic          out_valid2;
  logic [31:0]   out_pc1;
  logic [31:0]   out_inst1;
  logic [31:0]   out_pc2;
  logic [31:0]   out_inst2;
  logic          issue1;
  logic          issue2;
  logic [CW-1:0] count;

  modport slave (
    input  flush, in_valid1, in_valid2, in_pc1, in_inst1, in_pc2, in_inst2,
    input  issue1, issue2,
    output full, out_valid1, out_valid2, out_pc1, out_inst1, out_pc2, out_inst2,
    output count
  );

  modport master (
    output flush, in_valid1, in_valid2, in_pc1, in_inst1, in_pc2, in_inst2,
    output issue1, issue2,
    input  full, out_valid1, out_valid2, out_pc1, out_inst1, out_pc2, out_inst2,
    input  count
  );
endinterface

// File: rtl/inst_fifo.sv
// Dual-push / dual-pop instruction queue between fetch and decode (circular buffer of {pc, inst}).
// Optional macro INST_FIFO_BYPASS_EN forwards fetch slots straight to the issue ports when empty.
module inst_fifo #(
  parameter int DEPTH = 16
) (
  input logic         clk,
  input logic         resetn,
  inst_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr_p1;
  logic [AW-1:0] wr_ptr_p1;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic          full_i;
  logic          q_ge1;
  logic          q_ge2;
  logic [1:0]    n_push;
  logic [1:0]    n_req_pop;
  logic [1:0]    n_pop;
  logic [1:0]    n_byp;
  logic [1:0]    n_wr;
  logic [63:0]   ent0;
  logic [63:0]   ent1;
  logic [63:0]   wd0;
  logic [63:0]   wd1;
`ifdef INST_FIFO_BYPASS_EN
  logic          byp_act;
`endif

  // Push/pop accounting; entries are packed slot-1-first so a lone slot-2 push lands in ent0.
  always_comb begin
    full_i    = cnt > CW'(DEPTH - 2);
    q_ge1     = cnt != '0;
    q_ge2     = cnt >= CW'(2);
    ent0      = bus.in_valid1 ? {bus.in_pc1, bus.in_inst1} : {bus.in_pc2, bus.in_inst2};
    ent1      = {bus.in_pc2, bus.in_inst2};
    n_push    = full_i ? 2'd0 : ({1'b0, bus.in_valid1} + {1'b0, bus.in_valid2});
    n_req_pop = bus.issue1 ? (bus.issue2 ? 2'd2 : 2'd1) : 2'd0;
    if (n_req_pop == 2'd2 && q_ge2) begin
      n_pop = 2'd2;
    end else if (n_req_pop != 2'd0 && q_ge1) begin
      n_pop = 2'd1;
    end else begin
      n_pop = 2'd0;
    end
`ifdef INST_FIFO_BYPASS_EN
    // Entries consumed straight off the fetch slots are never written to the buffer.
    byp_act = !q_ge1 && !bus.flush;
    if (byp_act) begin
      n_byp = (n_req_pop < n_push) ? n_req_pop : n_push;
    end else begin
      n_byp = 2'd0;
    end
`else
    n_byp = 2'd0;
`endif
    n_wr      = n_push - n_byp;
    wd0       = (n_byp == 2'd1) ? ent1 : ent0;
    wd1       = ent1;
    cnt_nxt   = cnt + CW'(n_wr) - CW'(n_pop);
    rd_ptr_p1 = rd_ptr + AW'(1);
    wr_ptr_p1 = wr_ptr + AW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(n_pop);
      wr_ptr <= wr_ptr + AW'(n_wr);
      cnt    <= cnt_nxt;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (resetn && !bus.flush) begin
      if (n_wr != 2'd0) mem[wr_ptr] <= wd0;
      if (n_wr == 2'd2) mem[wr_ptr_p1] <= wd1;
    end
  end

  always_comb begin
    bus.full       = full_i;
    bus.count      = cnt;
    bus.out_valid1 = q_ge1;
    bus.out_valid2 = q_ge2;
    {bus.out_pc1, bus.out_inst1} = mem[rd_ptr];
    {bus.out_pc2, bus.out_inst2} = mem[rd_ptr_p1];
`ifdef INST_FIFO_BYPASS_EN
    if (byp_act) begin
      bus.out_valid1 = bus.in_valid1 | bus.in_valid2;
      bus.out_valid2 = bus.in_valid1 & bus.in_valid2;
      {bus.out_pc1, bus.out_inst1} = ent0;
      {bus.out_pc2, bus.out_inst2} = ent1;
    end
`endif
  end

  a_cnt_bound : assert property (@(posedge clk) disable iff (!resetn) cnt <= CW'(DEPTH));

endmodule

// File: tb/tb_inst_fifo.sv
// Bench for inst_fifo: directed vector table, hand-written corner sequences and random traffic
// compared against a queue-based model of the instruction queue.
module tb_inst_fifo;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  inst_fifo_if #(.DEPTH(DEPTH)) bus ();
  inst_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        v1;
    logic        v2;
    logic [31:0] p1;
    logic [31:0] p2;
    logic        s1;
    logic        s2;
    int          exp_count;
    logic        exp_full;
    logic        chk_o;
    logic        exp_ov1;
    logic [31:0] exp_pc1;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v1, input logic v2,
                       input logic [31:0] p1, input logic [31:0] i1,
                       input logic [31:0] p2, input logic [31:0] i2,
                       input logic s1, input logic s2, input logic f);
    bus.in_valid1 = v1;
    bus.in_valid2 = v2;
    bus.in_pc1    = p1;
    bus.in_inst1  = i1;
    bus.in_pc2    = p2;
    bus.in_inst2  = i2;
    bus.issue1    = s1;
    bus.issue2    = s2;
    bus.flush     = f;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Outputs the model expects for the inputs currently applied.
  task automatic model_check();
    logic [63:0] vis[$];
    vis = exp_q;
`ifdef INST_FIFO_BYPASS_EN
    if (exp_q.size() == 0 && !bus.flush) begin
      if (bus.in_valid1) vis.push_back({bus.in_pc1, bus.in_inst1});
      if (bus.in_valid2) vis.push_back({bus.in_pc2, bus.in_inst2});
    end
`endif
    chk("count", 64'(bus.count), 64'(exp_q.size()));
    chk("full", 64'(bus.full), 64'(exp_q.size() > DEPTH - 2));
    chk("out_valid1", 64'(bus.out_valid1), 64'(vis.size() >= 1));
    chk("out_valid2", 64'(bus.out_valid2), 64'(vis.size() >= 2));
    if (vis.size() >= 1) chk("out_slot1", {bus.out_pc1, bus.out_inst1}, vis[0]);
    if (vis.size() >= 2) chk("out_slot2", {bus.out_pc2, bus.out_inst2}, vis[1]);
  endtask

  task automatic model_update();
    int n;
    bit acc;
    bit byp;
    if (bus.flush) begin
      exp_q.delete();
    end else begin
      n   = bus.issue1 ? (bus.issue2 ? 2 : 1) : 0;
      acc = exp_q.size() <= DEPTH - 2;
      byp = 1'b0;
`ifdef INST_FIFO_BYPASS_EN
      byp = exp_q.size() == 0;
`endif
      if (!byp) repeat (n) if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        if (bus.in_valid1) exp_q.push_back({bus.in_pc1, bus.in_inst1});
        if (bus.in_valid2) exp_q.push_back({bus.in_pc2, bus.in_inst2});
      end
      if (byp) repeat (n) if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic finish_cycle();
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic push_pair(input logic [31:0] pc);
    drive(1'b1, 1'b1, pc, ~pc, pc + 32'd4, ~(pc + 32'd4), 1'b0, 1'b0, 1'b0);
    cycle();
  endtask

  task automatic push_one(input logic [31:0] pc);
    drive(1'b1, 1'b0, pc, ~pc, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    #2;
    chk("reset_count", 64'(bus.count), 64'd0);
    chk("reset_full", 64'(bus.full), 64'd0);
    chk("reset_ov1", 64'(bus.out_valid1), 64'd0);
    chk("reset_ov2", 64'(bus.out_valid2), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Fill to capacity, drop a ninth pair, then drain in pairs across the index wrap.
    for (int i = 0; i < 9; i++) begin
      tbl[i] = '{v1: 1'b1, v2: 1'b1, p1: 32'hBFC0_0000 + 32'(8 * i), p2: 32'hBFC0_0004 + 32'(8 * i),
                 s1: 1'b0, s2: 1'b0, exp_count: 2 * i, exp_full: (i == 8), chk_o: 1'b0,
                 exp_ov1: 1'b0, exp_pc1: 32'h0};
    end
    for (int i = 0; i < 8; i++) begin
      tbl[9 + i] = '{v1: 1'b0, v2: 1'b0, p1: 32'h0, p2: 32'h0, s1: 1'b1, s2: 1'b1,
                     exp_count: 16 - 2 * i, exp_full: (i == 0), chk_o: 1'b1, exp_ov1: 1'b1,
                     exp_pc1: 32'hBFC0_0000 + 32'(8 * i)};
    end
    tbl[17] = '{v1: 1'b0, v2: 1'b0, p1: 32'h0, p2: 32'h0, s1: 1'b0, s2: 1'b0, exp_count: 0,
                exp_full: 1'b0, chk_o: 1'b1, exp_ov1: 1'b0, exp_pc1: 32'h0};

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v1, tbl[i].v2, tbl[i].p1, 32'h1111_1111, tbl[i].p2, 32'h2222_2222,
            tbl[i].s1, tbl[i].s2, 1'b0);
      @(negedge clk);
      chk($sformatf("tbl%0d_count", i), 64'(bus.count), 64'(tbl[i].exp_count));
      chk($sformatf("tbl%0d_full", i), 64'(bus.full), 64'(tbl[i].exp_full));
      if (tbl[i].chk_o) begin
        chk($sformatf("tbl%0d_ov1", i), 64'(bus.out_valid1), 64'(tbl[i].exp_ov1));
        if (tbl[i].exp_ov1) chk($sformatf("tbl%0d_pc1", i), 64'(bus.out_pc1), 64'(tbl[i].exp_pc1));
      end
      finish_cycle();
    end

    // Count 3, push two and issue two together: count holds, old third entry moves to the head.
    push_pair(32'hBFC0_0100);
    push_one(32'hBFC0_0108);
    drive(1'b1, 1'b1, 32'hBFC0_010C, 32'h0, 32'hBFC0_0110, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle();
    idle();
    @(negedge clk);
    chk("pushpop_count", 64'(bus.count), 64'd3);
    chk("pushpop_pc1", 64'(bus.out_pc1), 64'h0000_0000_BFC0_0108);
    finish_cycle();

    // Count 5, flush with a push and an issue presented: everything discarded.
    push_pair(32'hBFC0_0200);
    drive(1'b1, 1'b1, 32'hBFC0_0300, 32'h0, 32'hBFC0_0304, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("preflush_count", 64'(bus.count), 64'd5);
    finish_cycle();
    idle();
    @(negedge clk);
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_ov1", 64'(bus.out_valid1), 64'd0);
    chk("flush_full", 64'(bus.full), 64'd0);
    finish_cycle();

    // Empty queue, single push with issue1 in the same cycle.
    drive(1'b1, 1'b0, 32'hBFC0_0010, 32'hABCD_0010, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
`ifdef INST_FIFO_BYPASS_EN
    chk("byp_ov1", 64'(bus.out_valid1), 64'd1);
    chk("byp_pc1", 64'(bus.out_pc1), 64'h0000_0000_BFC0_0010);
`else
    chk("lat_ov1", 64'(bus.out_valid1), 64'd0);
`endif
    finish_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
`ifdef INST_FIFO_BYPASS_EN
    chk("byp_count", 64'(bus.count), 64'd0);
`else
    chk("lat_ov1_next", 64'(bus.out_valid1), 64'd1);
    chk("lat_pc1_next", 64'(bus.out_pc1), 64'h0000_0000_BFC0_0010);
`endif
    finish_cycle();
    idle();
    cycle();

    // Reset mid-burst at count 9: clears before the next edge, then the first push issues first.
    for (int i = 0; i < 4; i++) push_pair(32'hBFC0_0400 + 32'(8 * i));
    push_one(32'hBFC0_0420);
    idle();
    @(negedge clk);
    chk("prereset_count", 64'(bus.count), 64'd9);
    resetn = 1'b0;
    #1;
    chk("midreset_count", 64'(bus.count), 64'd0);
    chk("midreset_ov1", 64'(bus.out_valid1), 64'd0);
    chk("midreset_full", 64'(bus.full), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    push_one(32'hBFC0_0500);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("postreset_pc1", 64'(bus.out_pc1), 64'h0000_0000_BFC0_0500);
    finish_cycle();

    // Random traffic against the model.
    for (int c = 0; c < 500; c++) begin
      logic [31:0] pa;
      logic [31:0] pb;
      pa = $urandom();
      pb = $urandom();
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pa, $urandom(), pb, $urandom(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
